// File: rtl/exec_muldiv_ctrl.sv
// exec_muldiv_ctrl -- iterative multiply/divide sequencer for the EX stage.
//
// Runs MULT/MULTU as a one-bit-per-cycle shift-add and DIV/DIVU as a
// restoring divide over WIDTH cycles, then one FIX cycle applies sign
// correction and writes the architectural HI/LO registers.
//
// Build option: define MULDIV_DIV_EN to build the divider. Without it, DIV/DIVU
// starts are ignored and o_div_zero is tied low.
//
// Ports:
//   i_clk        pipeline clock, all state on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      EX presents a mul/div op this cycle
//   i_op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_src_a      rs value (multiplicand / dividend)
//   i_src_b      rt value (multiplier / divisor)
//   i_flush      kill the in-flight op
//   i_wr_hi/lo   MTHI/MTLO strobes (honoured only while not busy)
//   i_wr_data    MTHI/MTLO data
//   o_busy       op in flight, hazard unit stalls dependents
//   o_done       one-cycle pulse, HI/LO updated on the previous edge
//   o_div_zero   pulses with o_done when the divisor was zero
//   o_hi, o_lo   architectural HI/LO
module exec_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_flush,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    // Upper half: partial product / remainder. Lower half: multiplier / quotient.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;      // multiplicand / divisor magnitude
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_q;    // product or quotient must be negated

    logic                 w_signed;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_op_ok;
    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_prod_fix;

    assign w_signed = ~i_op[0];
    assign w_sa     = w_signed & i_src_a[WIDTH-1];
    assign w_sb     = w_signed & i_src_b[WIDTH-1];
    // -2^(WIDTH-1) has no positive counterpart but its unsigned magnitude is exact.
    assign w_mag_a  = w_sa ? ({WIDTH{1'b0}} - i_src_a) : i_src_a;
    assign w_mag_b  = w_sb ? ({WIDTH{1'b0}} - i_src_b) : i_src_b;

`ifdef MULDIV_DIV_EN
    assign w_op_ok  = 1'b1;
`else
    assign w_op_ok  = ~i_op[1];
`endif
    assign w_accept = i_start & ~i_flush & w_op_ok & (r_state == S_IDLE);

    // Shift-add step: conditionally add the multiplicand, then shift the
    // (WIDTH+1)-bit sum and the remaining multiplier bits right by one.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
    logic                 r_is_div;
    logic                 r_neg_r;    // remainder takes the dividend's sign
    logic                 r_dz;
    logic                 w_b_zero;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_sub;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_b_zero    = (i_src_b == {WIDTH{1'b0}});
    // Restoring step: bring the next dividend bit into the remainder and
    // subtract; a set bit WIDTH means the trial went negative, so restore.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_opb};
    assign w_div_next  = w_div_sub[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_sub[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
    assign w_quo_fix   = r_neg_q ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem_fix   = r_neg_r ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH])
                                 : r_acc[2*WIDTH-1:WIDTH];
`else
    assign o_div_zero  = 1'b0;
`endif

    // Sequencer FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_opb    <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg_q  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_hi     <= {WIDTH{1'b0}};
            o_lo     <= {WIDTH{1'b0}};
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            o_div_zero <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef MULDIV_DIV_EN
            o_div_zero <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // Moves to HI/LO only land while idle; a same-cycle start
                    // later overwrites them with its result.
                    if (i_wr_hi) o_hi <= i_wr_data;
                    if (i_wr_lo) o_lo <= i_wr_data;
                    if (w_accept) begin
                        r_cnt   <= {CW{1'b0}};
                        r_neg_q <= w_sa ^ w_sb;
                        o_busy  <= 1'b1;
`ifdef MULDIV_DIV_EN
                        r_is_div <= i_op[1];
                        r_neg_r  <= w_sa;
                        r_dz     <= 1'b0;
                        if (i_op[1] && w_b_zero) begin
                            // Divide by zero: FIX writes these raw values.
                            r_acc    <= {i_src_a, {WIDTH{1'b1}}};
                            r_neg_q  <= 1'b0;
                            r_neg_r  <= 1'b0;
                            r_dz     <= 1'b1;
                            r_state  <= S_FIX;
                        end else
`endif
                        begin
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opb   <= w_mag_b;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (r_is_div) r_acc <= w_div_next;
                        else
`endif
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    if (!i_flush) begin
                        o_done <= 1'b1;
`ifdef MULDIV_DIV_EN
                        o_div_zero <= r_dz;
                        if (r_is_div) begin
                            o_hi <= w_rem_fix;
                            o_lo <= w_quo_fix;
                        end else
`endif
                        begin
                            o_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            o_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Scoreboard bench for exec_muldiv_ctrl: expected HI/LO/div_zero are pushed
// at issue time from an arithmetic reference model and popped by a monitor
// whenever o_done pulses.
module tb_exec_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'd0;
    logic [31:0] i_src_a = 32'd0;
    logic [31:0] i_src_b = 32'd0;
    logic        i_flush = 1'b0;
    logic        i_wr_hi = 1'b0;
    logic        i_wr_lo = 1'b0;
    logic [31:0] i_wr_data = 32'd0;
    logic        o_busy, o_done, o_div_zero;
    logic [31:0] o_hi, o_lo;

    exec_muldiv_ctrl #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_flush(i_flush),
        .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo), .i_wr_data(i_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
        .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_r;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model straight from the arithmetic definitions of each op.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit acc, output res_t r, output int cyc);
        longint sa, sb, q, rm;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        acc = 1'b1;
        cyc = 33;
        case (op)
            2'd0: begin p = longint'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (!DIV_EN) begin
                    acc = 1'b0;
                    cyc = 0;
                end else if (b == 32'd0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1; cyc = 1;
                end else if (op == 2'd2) begin
                    q = sa / sb; rm = sa % sb;
                    r.hi = rm[31:0]; r.lo = q[31:0];
                end else begin
                    r.hi = a % b; r.lo = a / b;
                end
            end
        endcase
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (i_rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
            end else begin
                mon_r = exp_q.pop_front();
                chk("done_hi", {32'd0, o_hi}, {32'd0, mon_r.hi});
                chk("done_lo", {32'd0, o_lo}, {32'd0, mon_r.lo});
                chk("done_div_zero", {63'd0, o_div_zero}, {63'd0, mon_r.dz});
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after busy drops.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit   acc;
        res_t r;
        int   cyc;
        int   n;
        model(op, a, b, acc, r, cyc);
        i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        if (acc) begin
            exp_q.push_back(r);
            m_hi = r.hi;
            m_lo = r.lo;
        end
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(cyc));
        chk("hi_after_op", {32'd0, o_hi}, {32'd0, m_hi});
        chk("lo_after_op", {32'd0, o_lo}, {32'd0, m_lo});
    endtask

    task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic write_hilo(input logic [31:0] d);
        i_wr_hi = 1'b1; i_wr_lo = 1'b1; i_wr_data = d;
        @(negedge clk);
        i_wr_hi = 1'b0; i_wr_lo = 1'b0;
        m_hi = d; m_lo = d;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_done", {63'd0, o_done}, 64'd0);
        chk("reset_hi", {32'd0, o_hi}, 64'd0);
        chk("reset_lo", {32'd0, o_lo}, 64'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the arithmetic corners.
        run_op(2'd1, 32'd10, 32'd12);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op(2'd3, 32'd100, 32'd7);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd5, 32'd0);

        // MTHI/MTLO, then a flushed MULT with ignored start/wr during busy.
        write_hilo(32'h55);
        chk("wr_hi", {32'd0, o_hi}, 64'h55);
        chk("wr_lo", {32'd0, o_lo}, 64'h55);
        start_only(2'd0, 32'd1234, 32'd5678);
        chk("busy_after_start", {63'd0, o_busy}, 64'd1);
        for (int i = 0; i < 9; i++) begin
            i_start = (i == 3);
            i_wr_hi = (i == 5);
            i_wr_data = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        i_start = 1'b0; i_wr_hi = 1'b0;
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("busy_after_flush", {63'd0, o_busy}, 64'd0);
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("hi_after_flush", {32'd0, o_hi}, 64'h55);
        chk("lo_after_flush", {32'd0, o_lo}, 64'h55);

        // start together with flush in IDLE is dropped.
        i_flush = 1'b1;
        start_only(2'd1, 32'd3, 32'd4);
        i_flush = 1'b0;
        chk("busy_start_flush", {63'd0, o_busy}, 64'd0);

        // Reset in the middle of CALC.
        start_only(2'd1, 32'd77, 32'd99);
        for (int i = 0; i < 19; i++) @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("midop_reset_busy", {63'd0, o_busy}, 64'd0);
        chk("midop_reset_done", {63'd0, o_done}, 64'd0);
        chk("midop_reset_hi", {32'd0, o_hi}, 64'd0);
        chk("midop_reset_lo", {32'd0, o_lo}, 64'd0);
        run_op(2'd1, 32'd10, 32'd12);

        // Randomized ops, issued back-to-back in the done cycle, with
        // occasional moves to HI/LO between them.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                write_hilo($urandom);
                chk("rand_wr_hi", {32'd0, o_hi}, {32'd0, m_hi});
            end
            run_op(2'($urandom_range(0, 3)), pick(), pick());
        end

        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so a stuck DUT can never hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
